wbs_kdtree_slave: RTL and testbench
===================================

Name: wbs_kdtree_slave

Overview:
- Wishbone classic slave (responder) between the Caravel management bus and the KD-tree ANN core.
- Decodes the fixed address map and drives write strobes into the internal-node, leaf and query-FIFO storage.
- Reads back the best-match array and the status/control registers.
- Converts single-word bus transactions into one-cycle core-side strobes and generates wbs_ack_o.

Parameters:
- DATA_WIDTH, 11, width of one patch/index/median word.
- NODE_AW, 6, internal-node address width (63 nodes used).
- MEM_AW, 14, leaf/best word-address width.

Ports:
- wb_clk_i  in  1  sole clock.
- rst_n  in  1  synchronous active-low reset.
- wbs_stb_i  in  1  strobe.
- wbs_cyc_i  in  1  cycle valid.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte enables.
- wbs_adr_i  in  32  address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- mode_o  out  1  mode register bit.
- debug_o  out  32  debug register.
- fsm_start_o  out  1  one-cycle start pulse.
- fsm_done_i  in  1  core done pulse.
- fsm_busy_i  in  1  core busy level.
- node_wen_o  out  1  node write strobe.
- node_addr_o  out  NODE_AW  node index.
- node_wdata_o  out  2*DATA_WIDTH  {median, index}.
- leaf_wen_o  out  1  leaf write strobe.
- leaf_addr_o  out  MEM_AW  leaf word address.
- leaf_wdata_o  out  DATA_WIDTH  leaf word.
- query_wenq_o  out  1  query FIFO enqueue.
- query_wdata_o  out  DATA_WIDTH  query word.
- query_wfull_n_i  in  1  query FIFO not full.
- best_ren_o  out  1  best-array read strobe.
- best_addr_o  out  MEM_AW  best-array address.
- best_rdata_i  in  DATA_WIDTH  read data, valid 1 cycle after best_ren_o.

Behaviour:
- Clock and reset: one clock, wb_clk_i; reset rst_n is synchronous and active-low. Reset forces all outputs, registers and FSM to 0/IDLE on the next edge, including mid-transaction; no ack is issued for an aborted transaction.
- Request: req = wbs_cyc_i & wbs_stb_i, sampled only in IDLE.
- Window select (adr[31:16]): 0x3000 = control, 0x3001 = query, 0x3002 = leaf, 0x3003 = best, 0x3004 = node.
- Control offsets (adr[7:0]): 0x00 mode, 0x04 debug, 0x08 done, 0x0C fsm_start, 0x10 fsm_busy.
- Memory windows are word-indexed by the raw low address bits: node = adr[NODE_AW-1:0]; leaf/best = adr[MEM_AW-1:0]. Data is taken from dat_i[DATA_WIDTH-1:0]; node data is dat_i[2*DATA_WIDTH-1:0].
- FSM states: IDLE, ACK, BEST_WAIT, QUERY_WAIT.
- Register or memory write, or register read: req seen at edge N -> strobe (node/leaf wen, register update) high in cycle N+1 together with wbs_ack_o; then IDLE.
- Best read: edge N best_ren_o=1 -> BEST_WAIT captures best_rdata_i zero-extended -> ack at N+2.
- Query write:
  - If query_wfull_n_i=1, query_wenq_o and ack are issued as for a plain write.
  - Otherwise go to QUERY_WAIT; enqueue plus ack occur the cycle after wfull_n rises.
  - Never enqueue when full.
- Abort: wbs_cyc_i falling in BEST_WAIT or QUERY_WAIT returns to IDLE with no ack and no enqueue.
- Ack pulse: wbs_ack_o is exactly one cycle per transaction. The FSM returns to IDLE after ACK, so stb held high starts the next transaction one cycle later (minimum 2 cycles per transaction).
- wbs_dat_o is valid only while ack=1 and is 0 otherwise; write acks return 0.
- mode: write latches dat_i[0] if sel[0]; reads return {31'b0, mode}.
- debug: 32-bit register with per-byte sel enables.
- done: sticky, set by fsm_done_i, cleared by any write to 0x08. Simultaneous set and clear leaves it set.
- fsm_start: write with dat_i[0]=1 pulses fsm_start_o for one cycle, coincident with ack. It is ignored if fsm_busy_i=1, but still acked.
- Undecoded window or offset: ack with data 0, no side effects. Writes to read-only done/busy are acked and ignored.

Decomposition:
- Package kdtree_wbs_pkg: window constants, offset constants, address mask 0xFFFF_0000, and state enum.
- Sub-module wbs_addr_decode: combinational window/offset decode to a one-hot select.

Test Plan:
- Node write adr 0x3004_0001, dat {10'b0, 11'd55, 11'd1}, then a read on held stb -> node_wen_o for one cycle with addr 1, wdata {55,1}; one ack per transaction, 2 cycles apart.
- Best read adr 0x3003_0005 with best_rdata_i=0x2A -> best_ren_o at N+1, ack at N+2, wbs_dat_o=0x0000_002A.
- Query write with query_wfull_n_i=0 for 5 cycles, then 1 -> no ack while full; enqueue and ack the cycle after release; exactly one enqueue.
- Write 0x3000_000C dat 1 with busy=0, then again with busy=1 -> one fsm_start_o pulse only; both writes acked.
- fsm_done_i pulse, read 0x08 -> 1; write 0x08 in the same cycle as a second done pulse -> still 1.
- Read 0x3005_0000, then drop rst_n during QUERY_WAIT -> first returns ack with data 0; second gets no ack and all outputs are 0 the next edge.

Source files
------------

// File: rtl/wbs_kdtree_slave_pkg.sv
// Shared address map, register offsets, FSM state type and decode select
// bundle for the KD-tree Wishbone slave.
package kdtree_wbs_pkg;

  localparam logic [31:0] ADDR_MASK = 32'hFFFF_0000;

  localparam logic [15:0] WIN_CTRL  = 16'h3000;
  localparam logic [15:0] WIN_QUERY = 16'h3001;
  localparam logic [15:0] WIN_LEAF  = 16'h3002;
  localparam logic [15:0] WIN_BEST  = 16'h3003;
  localparam logic [15:0] WIN_NODE  = 16'h3004;

  localparam logic [7:0] OFF_MODE  = 8'h00;
  localparam logic [7:0] OFF_DEBUG = 8'h04;
  localparam logic [7:0] OFF_DONE  = 8'h08;
  localparam logic [7:0] OFF_START = 8'h0C;
  localparam logic [7:0] OFF_BUSY  = 8'h10;

  typedef enum logic [1:0] {IDLE, ACK, BEST_WAIT, QUERY_WAIT} state_t;

  // One-hot target select; all-zero means an undecoded address.
  typedef struct packed {
    logic mode;
    logic debug;
    logic done;
    logic start;
    logic busy;
    logic query;
    logic leaf;
    logic best;
    logic node;
  } sel_t;

  function automatic logic [15:0] window_of(input logic [31:0] adr);
    return 16'((adr & ADDR_MASK) >> 16);
  endfunction

endpackage

// File: rtl/wbs_kdtree_slave_if.sv
// Wishbone classic bus bundle between the management SoC and the KD-tree slave.
interface wbs_kdtree_slave_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wbs_kdtree_slave_addr_decode.sv
// Combinational window/offset decode into a one-hot target select.
module wbs_addr_decode
  import kdtree_wbs_pkg::*;
(
  input  logic [15:0] window,
  input  logic [7:0]  offset,
  output sel_t        sel
);

  always_comb begin
    sel = '0;
    case (window)
      WIN_CTRL: begin
        case (offset)
          OFF_MODE:  sel.mode  = 1'b1;
          OFF_DEBUG: sel.debug = 1'b1;
          OFF_DONE:  sel.done  = 1'b1;
          OFF_START: sel.start = 1'b1;
          OFF_BUSY:  sel.busy  = 1'b1;
          default:   ;
        endcase
      end
      WIN_QUERY: sel.query = 1'b1;
      WIN_LEAF:  sel.leaf  = 1'b1;
      WIN_BEST:  sel.best  = 1'b1;
      WIN_NODE:  sel.node  = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: rtl/wbs_kdtree_slave.sv
// Wishbone classic slave for the KD-tree ANN core: address decode, one-cycle
// core-side write strobes, best-array readback and status/control registers.
module wbs_kdtree_slave
  import kdtree_wbs_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 11,
  parameter int unsigned NODE_AW    = 6,
  parameter int unsigned MEM_AW     = 14
) (
  input  logic                    wb_clk_i,
  input  logic                    rst_n,
  wbs_kdtree_slave_if.slave       wb,
  output logic                    mode_o,
  output logic [31:0]             debug_o,
  output logic                    fsm_start_o,
  input  logic                    fsm_done_i,
  input  logic                    fsm_busy_i,
  output logic                    node_wen_o,
  output logic [NODE_AW-1:0]      node_addr_o,
  output logic [2*DATA_WIDTH-1:0] node_wdata_o,
  output logic                    leaf_wen_o,
  output logic [MEM_AW-1:0]       leaf_addr_o,
  output logic [DATA_WIDTH-1:0]   leaf_wdata_o,
  output logic                    query_wenq_o,
  output logic [DATA_WIDTH-1:0]   query_wdata_o,
  input  logic                    query_wfull_n_i,
  output logic                    best_ren_o,
  output logic [MEM_AW-1:0]       best_addr_o,
  input  logic [DATA_WIDTH-1:0]   best_rdata_i
);

  state_t state, state_n;
  sel_t   sel;
  logic   req;

  logic                    ack_q, ack_n, mode_q, mode_n, done_q, done_n, start_q, start_n;
  logic [31:0]             dat_q, dat_n, debug_q, debug_n;
  logic                    node_wen_q, node_wen_n, leaf_wen_q, leaf_wen_n;
  logic                    enq_q, enq_n, ren_q, ren_n;
  logic [NODE_AW-1:0]      node_addr_q, node_addr_n;
  logic [2*DATA_WIDTH-1:0] node_wdata_q, node_wdata_n;
  logic [MEM_AW-1:0]       leaf_addr_q, leaf_addr_n, best_addr_q, best_addr_n;
  logic [DATA_WIDTH-1:0]   leaf_wdata_q, leaf_wdata_n, qdata_q, qdata_n;

  assign req = wb.wbs_cyc_i & wb.wbs_stb_i;

  wbs_addr_decode u_decode (
    .window (window_of(wb.wbs_adr_i)),
    .offset (wb.wbs_adr_i[7:0]),
    .sel    (sel)
  );

  // Every output is registered so that strobes land in the same cycle as ack
  // and a synchronous reset clears them all on one edge.
  always_comb begin
    state_n      = state;
    ack_n        = 1'b0;
    dat_n        = '0;
    mode_n       = mode_q;
    debug_n      = debug_q;
    done_n       = done_q | fsm_done_i;
    start_n      = 1'b0;
    node_wen_n   = 1'b0;
    node_addr_n  = '0;
    node_wdata_n = '0;
    leaf_wen_n   = 1'b0;
    leaf_addr_n  = '0;
    leaf_wdata_n = '0;
    enq_n        = 1'b0;
    qdata_n      = '0;
    ren_n        = 1'b0;
    best_addr_n  = '0;

    unique case (state)
      IDLE: begin
        if (req) begin
          if (sel.best && !wb.wbs_we_i) begin
            ren_n       = 1'b1;
            best_addr_n = wb.wbs_adr_i[MEM_AW-1:0];
            state_n     = BEST_WAIT;
          end else if (sel.query && wb.wbs_we_i) begin
            if (query_wfull_n_i) begin
              enq_n   = 1'b1;
              qdata_n = wb.wbs_dat_i[DATA_WIDTH-1:0];
              ack_n   = 1'b1;
              state_n = ACK;
            end else begin
              state_n = QUERY_WAIT;
            end
          end else begin
            ack_n   = 1'b1;
            state_n = ACK;
            if (wb.wbs_we_i) begin
              if (sel.node) begin
                node_wen_n   = 1'b1;
                node_addr_n  = wb.wbs_adr_i[NODE_AW-1:0];
                node_wdata_n = wb.wbs_dat_i[2*DATA_WIDTH-1:0];
              end
              if (sel.leaf) begin
                leaf_wen_n   = 1'b1;
                leaf_addr_n  = wb.wbs_adr_i[MEM_AW-1:0];
                leaf_wdata_n = wb.wbs_dat_i[DATA_WIDTH-1:0];
              end
              if (sel.mode && wb.wbs_sel_i[0]) mode_n = wb.wbs_dat_i[0];
              if (sel.debug) begin
                for (int unsigned b = 0; b < 4; b++)
                  if (wb.wbs_sel_i[b]) debug_n[8*b +: 8] = wb.wbs_dat_i[8*b +: 8];
              end
              // A done pulse in the clearing cycle wins over the clear.
              if (sel.done)  done_n  = fsm_done_i;
              if (sel.start) start_n = wb.wbs_dat_i[0] & ~fsm_busy_i;
            end else begin
              if (sel.mode)  dat_n = {31'b0, mode_q};
              if (sel.debug) dat_n = debug_q;
              if (sel.done)  dat_n = {31'b0, done_q};
              if (sel.busy)  dat_n = {31'b0, fsm_busy_i};
            end
          end
        end
      end
      ACK: state_n = IDLE;
      BEST_WAIT: begin
        if (!wb.wbs_cyc_i) begin
          state_n = IDLE;
        end else begin
          ack_n   = 1'b1;
          dat_n   = 32'(best_rdata_i);
          state_n = ACK;
        end
      end
      QUERY_WAIT: begin
        if (!wb.wbs_cyc_i) begin
          state_n = IDLE;
        end else if (query_wfull_n_i) begin
          enq_n   = 1'b1;
          qdata_n = wb.wbs_dat_i[DATA_WIDTH-1:0];
          ack_n   = 1'b1;
          state_n = ACK;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!rst_n) begin
      state        <= IDLE;
      ack_q        <= 1'b0;
      dat_q        <= '0;
      mode_q       <= 1'b0;
      debug_q      <= '0;
      done_q       <= 1'b0;
      start_q      <= 1'b0;
      node_wen_q   <= 1'b0;
      node_addr_q  <= '0;
      node_wdata_q <= '0;
      leaf_wen_q   <= 1'b0;
      leaf_addr_q  <= '0;
      leaf_wdata_q <= '0;
      enq_q        <= 1'b0;
      qdata_q      <= '0;
      ren_q        <= 1'b0;
      best_addr_q  <= '0;
    end else begin
      state        <= state_n;
      ack_q        <= ack_n;
      dat_q        <= dat_n;
      mode_q       <= mode_n;
      debug_q      <= debug_n;
      done_q       <= done_n;
      start_q      <= start_n;
      node_wen_q   <= node_wen_n;
      node_addr_q  <= node_addr_n;
      node_wdata_q <= node_wdata_n;
      leaf_wen_q   <= leaf_wen_n;
      leaf_addr_q  <= leaf_addr_n;
      leaf_wdata_q <= leaf_wdata_n;
      enq_q        <= enq_n;
      qdata_q      <= qdata_n;
      ren_q        <= ren_n;
      best_addr_q  <= best_addr_n;
    end
  end

  assign wb.wbs_ack_o   = ack_q;
  assign wb.wbs_dat_o   = dat_q;
  assign mode_o         = mode_q;
  assign debug_o        = debug_q;
  assign fsm_start_o    = start_q;
  assign node_wen_o     = node_wen_q;
  assign node_addr_o    = node_addr_q;
  assign node_wdata_o   = node_wdata_q;
  assign leaf_wen_o     = leaf_wen_q;
  assign leaf_addr_o    = leaf_addr_q;
  assign leaf_wdata_o   = leaf_wdata_q;
  assign query_wenq_o   = enq_q;
  assign query_wdata_o  = qdata_q;
  assign best_ren_o     = ren_q;
  assign best_addr_o    = best_addr_q;

endmodule

// File: tb/tb_wbs_kdtree_slave.sv
// Self-checking bench for wbs_kdtree_slave: register table, timing corner
// sequences and a randomized run against a behavioural register/memory model.
module tb_wbs_kdtree_slave;
  import kdtree_wbs_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode_o, fsm_start_o, fsm_done_i, fsm_busy_i;
  logic [31:0] debug_o;
  logic        node_wen_o, leaf_wen_o, query_wenq_o, query_wfull_n_i, best_ren_o;
  logic [5:0]  node_addr_o;
  logic [21:0] node_wdata_o;
  logic [13:0] leaf_addr_o, best_addr_o;
  logic [10:0] leaf_wdata_o, query_wdata_o, best_rdata_i;

  logic [10:0] best_mem [0:16383];

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0, ack_cnt = 0, node_cnt = 0, leaf_cnt = 0, enq_cnt = 0, start_cnt = 0;
  logic [5:0]  last_node_addr;
  logic [21:0] last_node_data;
  logic [13:0] last_leaf_addr;
  logic [10:0] last_leaf_data, last_q_data;

  wbs_kdtree_slave_if bus ();

  wbs_kdtree_slave #(.DATA_WIDTH(11), .NODE_AW(6), .MEM_AW(14)) dut (
    .wb_clk_i        (clk),
    .rst_n           (rst_n),
    .wb              (bus),
    .mode_o          (mode_o),
    .debug_o         (debug_o),
    .fsm_start_o     (fsm_start_o),
    .fsm_done_i      (fsm_done_i),
    .fsm_busy_i      (fsm_busy_i),
    .node_wen_o      (node_wen_o),
    .node_addr_o     (node_addr_o),
    .node_wdata_o    (node_wdata_o),
    .leaf_wen_o      (leaf_wen_o),
    .leaf_addr_o     (leaf_addr_o),
    .leaf_wdata_o    (leaf_wdata_o),
    .query_wenq_o    (query_wenq_o),
    .query_wdata_o   (query_wdata_o),
    .query_wfull_n_i (query_wfull_n_i),
    .best_ren_o      (best_ren_o),
    .best_addr_o     (best_addr_o),
    .best_rdata_i    (best_rdata_i)
  );

  always #5 clk = ~clk;

  assign best_rdata_i = best_mem[best_addr_o];

  always @(posedge clk) cyc_cnt++;

  always @(negedge clk) begin
    if (bus.wbs_ack_o) ack_cnt++;
    if (node_wen_o) begin node_cnt++; last_node_addr = node_addr_o; last_node_data = node_wdata_o; end
    if (leaf_wen_o) begin leaf_cnt++; last_leaf_addr = leaf_addr_o; last_leaf_data = leaf_wdata_o; end
    if (query_wenq_o) begin enq_cnt++; last_q_data = query_wdata_o; end
    if (fsm_start_o) start_cnt++;
    if (node_wen_o || leaf_wen_o || query_wenq_o || fsm_start_o) begin
      checks++;
      if (!bus.wbs_ack_o) begin
        errors++;
        $display("FAIL strobe_with_ack: ack=%0b required 1 at cycle %0d", bus.wbs_ack_o, cyc_cnt);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_adr_i = adr;  bus.wbs_dat_i = dat;  bus.wbs_sel_i = sel;
  endtask

  task automatic release_bus();
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
  endtask

  // Single transaction; lat is the number of edges from request to visible ack.
  task automatic do_txn(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, output logic [31:0] rd, output int lat);
    drive(we, adr, dat, sel);
    lat = 0; rd = '0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus.wbs_ack_o) begin lat = i; rd = bus.wbs_dat_o; break; end
    end
    release_bus();
    if (lat == 0) begin
      checks++; errors++;
      $display("FAIL txn_timeout: no ack for adr 0x%08h within 20 cycles", adr);
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"}, 32'(bus.wbs_ack_o), 0);
    chk({tag, "_dat"}, bus.wbs_dat_o, 0);
    chk({tag, "_mode_debug"}, debug_o | 32'(mode_o), 0);
    chk({tag, "_strobes"}, 32'({fsm_start_o, node_wen_o, leaf_wen_o, query_wenq_o, best_ren_o}), 0);
    chk({tag, "_addrs"}, 32'(node_addr_o) | 32'(leaf_addr_o) | 32'(best_addr_o), 0);
    chk({tag, "_wdata"}, 32'(node_wdata_o) | 32'(leaf_wdata_o) | 32'(query_wdata_o), 0);
  endtask

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    bit          busy;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs [13];

  initial begin : main
    logic [31:0] rd, exp, d, adr;
    logic [3:0]  s;
    int          lat, explat, c0, c1, t1;
    logic        m_mode, m_done;
    logic [31:0] m_debug;
    logic [5:0]  a6;
    logic [13:0] a14;

    for (int i = 0; i < 16384; i++) best_mem[i] = 11'($urandom);
    best_mem[5] = 11'h02A;

    rst_n = 1'b0; fsm_done_i = 1'b0; fsm_busy_i = 1'b0; query_wfull_n_i = 1'b1;
    bus.wbs_sel_i = '0; bus.wbs_adr_i = '0; bus.wbs_dat_i = '0;
    release_bus();
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Register table
    vecs[0]  = '{1'b1, 32'h3000_0000, 32'h0000_0001, 4'h1, 1'b0, 32'h0,         "wr_mode"};
    vecs[1]  = '{1'b0, 32'h3000_0000, 32'h0,         4'hF, 1'b0, 32'h1,         "rd_mode"};
    vecs[2]  = '{1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0,         "wr_debug"};
    vecs[3]  = '{1'b0, 32'h3000_0004, 32'h0,         4'hF, 1'b0, 32'hDEAD_BEEF, "rd_debug"};
    vecs[4]  = '{1'b1, 32'h3000_0004, 32'h0000_5500, 4'h2, 1'b0, 32'h0,         "wr_debug_b1"};
    vecs[5]  = '{1'b0, 32'h3000_0004, 32'h0,         4'hF, 1'b0, 32'hDEAD_55EF, "rd_debug_b1"};
    vecs[6]  = '{1'b1, 32'h3000_0000, 32'h0,         4'h0, 1'b0, 32'h0,         "wr_mode_nosel"};
    vecs[7]  = '{1'b0, 32'h3000_0000, 32'h0,         4'hF, 1'b0, 32'h1,         "rd_mode_kept"};
    vecs[8]  = '{1'b0, 32'h3000_0010, 32'h0,         4'hF, 1'b1, 32'h1,         "rd_busy1"};
    vecs[9]  = '{1'b0, 32'h3000_0010, 32'h0,         4'hF, 1'b0, 32'h0,         "rd_busy0"};
    vecs[10] = '{1'b0, 32'h3000_0020, 32'h0,         4'hF, 1'b0, 32'h0,         "rd_bad_off"};
    vecs[11] = '{1'b0, 32'h3000_000C, 32'h0,         4'hF, 1'b0, 32'h0,         "rd_start"};
    vecs[12] = '{1'b1, 32'h3000_0010, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0,         "wr_busy_ro"};
    for (int i = 0; i < 13; i++) begin
      fsm_busy_i = vecs[i].busy;
      do_txn(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, rd, lat);
      chk(vecs[i].name, rd, vecs[i].exp);
      chk({vecs[i].name, "_lat"}, 32'(lat), 1);
    end
    fsm_busy_i = 1'b0;
    chk("mode_o", 32'(mode_o), 1);
    chk("debug_o", debug_o, 32'hDEAD_55EF);

    // Node write then a read on held strobe
    c0 = node_cnt; c1 = ack_cnt;
    drive(1'b1, 32'h3004_0001, 32'h0001_B801, 4'hF);
    t1 = 0;
    for (int i = 0; i < 10 && t1 == 0; i++) begin @(posedge clk); #1; if (bus.wbs_ack_o) t1 = cyc_cnt; end
    bus.wbs_we_i = 1'b0;
    lat = 0;
    for (int i = 0; i < 10 && lat == 0; i++) begin @(posedge clk); #1; if (bus.wbs_ack_o) lat = cyc_cnt - t1; end
    release_bus();
    @(posedge clk); #1;
    chk("node_gap", 32'(lat), 2);
    chk("node_acks", 32'(ack_cnt - c1), 2);
    chk("node_wen_cnt", 32'(node_cnt - c0), 1);
    chk("node_addr", 32'(last_node_addr), 1);
    chk("node_wdata", 32'(last_node_data), {10'b0, 11'd55, 11'd1});

    // Best read timing
    drive(1'b0, 32'h3003_0005, 32'h0, 4'hF);
    @(posedge clk); #1;
    chk("best_ren_n1", 32'({best_ren_o, bus.wbs_ack_o}), 32'b10);
    chk("best_addr", 32'(best_addr_o), 5);
    @(posedge clk); #1;
    chk("best_ack_n2", 32'({best_ren_o, bus.wbs_ack_o}), 32'b01);
    chk("best_data", bus.wbs_dat_o, 32'h0000_002A);
    release_bus();
    @(posedge clk); #1;

    // Query write held off by a full FIFO
    c0 = enq_cnt; c1 = ack_cnt;
    query_wfull_n_i = 1'b0;
    drive(1'b1, 32'h3001_0000, 32'hFFFF_F123, 4'hF);
    repeat (5) @(posedge clk);
    #1;
    chk("qfull_noack", 32'(ack_cnt - c1), 0);
    chk("qfull_noenq", 32'(enq_cnt - c0), 0);
    query_wfull_n_i = 1'b1;
    @(posedge clk); #1;
    chk("qrel_ack_enq", 32'({bus.wbs_ack_o, query_wenq_o}), 32'b11);
    chk("qrel_data", 32'(query_wdata_o), 32'h123);
    release_bus();
    repeat (2) @(posedge clk);
    #1;
    chk("qrel_one_enq", 32'(enq_cnt - c0), 1);

    // fsm_start gated by busy
    c0 = start_cnt;
    do_txn(1'b1, 32'h3000_000C, 32'h1, 4'hF, rd, lat);
    chk("start_idle", 32'(start_cnt - c0), 1);
    fsm_busy_i = 1'b1;
    do_txn(1'b1, 32'h3000_000C, 32'h1, 4'hF, rd, lat);
    chk("start_busy_ack", 32'(lat), 1);
    chk("start_busy_ignored", 32'(start_cnt - c0), 1);
    fsm_busy_i = 1'b0;

    // Sticky done, clear vs simultaneous set
    fsm_done_i = 1'b1; @(posedge clk); #1; fsm_done_i = 1'b0;
    do_txn(1'b0, 32'h3000_0008, 32'h0, 4'hF, rd, lat);
    chk("done_set", rd, 1);
    drive(1'b1, 32'h3000_0008, 32'h0, 4'hF);
    fsm_done_i = 1'b1;
    @(posedge clk); #1;
    fsm_done_i = 1'b0;
    chk("done_clr_ack", 32'(bus.wbs_ack_o), 1);
    release_bus();
    @(posedge clk); #1;
    do_txn(1'b0, 32'h3000_0008, 32'h0, 4'hF, rd, lat);
    chk("done_set_wins", rd, 1);
    do_txn(1'b1, 32'h3000_0008, 32'h0, 4'hF, rd, lat);
    do_txn(1'b0, 32'h3000_0008, 32'h0, 4'hF, rd, lat);
    chk("done_cleared", rd, 0);

    // Aborts in QUERY_WAIT and BEST_WAIT
    c0 = enq_cnt; c1 = ack_cnt;
    query_wfull_n_i = 1'b0;
    drive(1'b1, 32'h3001_0000, 32'h55, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    release_bus();
    @(posedge clk); #1;
    query_wfull_n_i = 1'b1;
    drive(1'b0, 32'h3003_0005, 32'h0, 4'hF);
    @(posedge clk); #1;
    release_bus();
    repeat (3) @(posedge clk);
    #1;
    chk("abort_noack", 32'(ack_cnt - c1), 0);
    chk("abort_noenq", 32'(enq_cnt - c0), 0);

    // Undecoded read, then reset during QUERY_WAIT
    do_txn(1'b0, 32'h3005_0000, 32'h0, 4'hF, rd, lat);
    chk("undecoded_data", rd, 0);
    chk("undecoded_lat", 32'(lat), 1);
    c0 = enq_cnt; c1 = ack_cnt;
    query_wfull_n_i = 1'b0;
    drive(1'b1, 32'h3001_0000, 32'h77, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("midrst");
    release_bus();
    query_wfull_n_i = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_noack", 32'(ack_cnt - c1), 0);
    chk("midrst_noenq", 32'(enq_cnt - c0), 0);

    // Randomized run against a behavioural model (state is all-zero after reset)
    m_mode = 1'b0; m_debug = '0; m_done = 1'b0;
    for (int n = 0; n < 200; n++) begin
      d = $urandom; s = 4'($urandom); exp = '0; explat = 1;
      c0 = node_cnt + leaf_cnt + enq_cnt + start_cnt;
      case ($urandom_range(0, 11))
        0: begin do_txn(1'b1, 32'h3000_0000, d, s, rd, lat); if (s[0]) m_mode = d[0]; end
        1: begin do_txn(1'b0, 32'h3000_0000, d, s, rd, lat); exp = {31'b0, m_mode}; end
        2: begin
          do_txn(1'b1, 32'h3000_0004, d, s, rd, lat);
          for (int b = 0; b < 4; b++) if (s[b]) m_debug[8*b +: 8] = d[8*b +: 8];
        end
        3: begin do_txn(1'b0, 32'h3000_0004, d, s, rd, lat); exp = m_debug; end
        4: begin
          a6 = 6'($urandom);
          do_txn(1'b1, {16'h3004, 10'($urandom), a6}, d, s, rd, lat);
          chk("rnd_node", {node_cnt - c0 == 0 ? 10'h3FF : 10'h0, last_node_data}, {10'h0, d[21:0]});
          chk("rnd_node_addr", 32'(last_node_addr), 32'(a6));
        end
        5: begin
          a14 = 14'($urandom);
          do_txn(1'b1, {16'h3002, 2'($urandom), a14}, d, s, rd, lat);
          chk("rnd_leaf", {leaf_cnt - c0 == 0 ? 7'h7F : 7'h0, last_leaf_addr, last_leaf_data},
              {7'h0, a14, d[10:0]});
        end
        6: begin
          a14 = 14'($urandom);
          do_txn(1'b0, {16'h3003, 2'($urandom), a14}, d, s, rd, lat);
          exp = 32'(best_mem[a14]); explat = 2;
        end
        7: begin
          do_txn(1'b1, 32'h3001_0000 | 32'($urandom_range(0, 65535)), d, s, rd, lat);
          chk("rnd_query", 32'(last_q_data), 32'(d[10:0]));
        end
        8: begin
          fsm_busy_i = 1'($urandom);
          do_txn(1'b0, 32'h3000_0010, d, s, rd, lat);
          exp = {31'b0, fsm_busy_i};
          fsm_busy_i = 1'b0;
        end
        9: begin
          fsm_done_i = 1'b1; @(posedge clk); #1; fsm_done_i = 1'b0; m_done = 1'b1;
          do_txn(1'b0, 32'h3000_0008, d, s, rd, lat); exp = {31'b0, m_done};
        end
        10: begin
          if (d[0]) begin do_txn(1'b1, 32'h3000_0008, d, s, rd, lat); m_done = 1'b0; end
          else begin do_txn(1'b0, 32'h3000_0008, d, s, rd, lat); exp = {31'b0, m_done}; end
        end
        default: begin
          adr = {16'($urandom_range(32'h3005, 32'hFFFF)), 16'($urandom)};
          do_txn(d[31], adr, d, s, rd, lat);
          chk("rnd_undecoded_side", 32'(node_cnt + leaf_cnt + enq_cnt + start_cnt - c0), 0);
        end
      endcase
      chk("rnd_data", rd, exp);
      chk("rnd_lat", 32'(lat), 32'(explat));
    end
    chk("rnd_mode_o", 32'(mode_o), 32'(m_mode));
    chk("rnd_debug_o", debug_o, m_debug);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc_cnt);
    $fatal(1, "watchdog expired");
  end

endmodule
